tdc_readout_arbiter: RTL and testbench
======================================

# tdc_readout_arbiter

Parametrised N-channel readout arbiter that drains the per-TDC 40-bit matched-hit FIFOs produced by the TDC decoders. It merges them into a single back-pressured stream for the CSM event builder, in the 160 MHz system domain. Channel selection is round-robin or fixed-priority, and each grant can be limited to a programmable burst length. The block also provides a per-channel enable mask and saturating per-channel word counters. It replaces the one-decoder, one-FIFO readout path when a CSM hosts many TDCs.

## Interface
Parameters:
- NUM_TDC, 18, number of TDC FIFO channels (2..32)
- DATA_W, 40, FIFO word width ({csm_id, tdc_id, hit})
- CNT_W, 32, width of each per-channel word counter
- OUT_DEPTH, 4, output buffer depth (power of two, ≥4)

Ports:
- sys_clk_160  in  1  system clock; the only clock
- rst_160_n  in  1  asynchronous, active-low reset
- tdc_fifo_empty  in  NUM_TDC  per-channel FIFO empty flag (standard FIFO, not FWFT)
- tdc_fifo_read  out  NUM_TDC  per-channel read enable, one-hot or zero
- tdc_fifo_data  in  NUM_TDC*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- tdc_enable_mask  in  NUM_TDC  1 = channel may be granted
- priority_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- max_burst  in  8  maximum words per grant; 0 = unlimited
- clear_counters  in  1  synchronous clear of all word counters
- out_data  out  DATA_W  merged output word
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- active_channel  out  5  index of the currently granted channel
- arbiter_busy  out  1  high while in GRANT or while words are in flight or buffered
- word_count  out  NUM_TDC*CNT_W  per-channel count of words read, saturating

## Operation
- FSM states: IDLE and GRANT.
- IDLE:
  - Compute the candidate set: ~tdc_fifo_empty & tdc_enable_mask.
  - If the set is non-empty, select a channel and go to GRANT. Otherwise stay in IDLE.
  - Round-robin selection: first candidate at or after rr_ptr, wrapping at NUM_TDC.
  - Fixed-priority selection: lowest-index candidate.
  - On grant: latch active_channel, clear burst_cnt, set rr_ptr = selected+1 (wraps to 0).
  - priority_mode and max_burst are sampled only in IDLE.
- GRANT:
  - Assert tdc_fifo_read[active] combinationally in any cycle where all three hold: !tdc_fifo_empty[active], tdc_enable_mask[active], and occ + inflight < OUT_DEPTH.
  - occ is the output buffer occupancy; inflight is 1 if a read was issued in the previous cycle.
  - Each read increments burst_cnt.
  - Return to IDLE in the cycle after any of: fifo empty seen, mask bit cleared, or burst_cnt reaches max_burst (when max_burst ≠ 0).
  - No read is issued in the exit cycle itself.
- Data capture:
  - The word from channel c, read in cycle N, is taken from tdc_fifo_data[c] in cycle N+1 and written to the output buffer.
  - The channel index c is pipelined alongside the read, not re-read from active_channel.
- Output buffer: OUT_DEPTH-entry FIFO.
  - out_valid = occ ≠ 0.
  - out_data = head word.
  - The credit rule guarantees it never overflows. An overflow is a design error; the bench checks it by assertion.
- Counters:
  - word_count[c] increments on each read of channel c and saturates at all-ones.
  - clear_counters has priority over an increment in the same cycle.
- Word contents are passed unmodified. Word order is preserved within each channel.

## Timing
- Reset (asynchronous assert, release synchronised by the caller) sets:
  - outputs: tdc_fifo_read=0, out_valid=0, out_data=0, active_channel=0, arbiter_busy=0, all word_count=0
  - internal: rr_ptr=0, state IDLE
- Reset mid-operation: the buffer and any in-flight word are discarded. The word read in the reset cycle is lost. This is accepted.
- Latency, with a candidate first visible in IDLE at cycle N0:
  - tdc_fifo_read in cycle N0+1
  - out_valid in cycle N0+3
- Throughput: with out_ready held high, one word per cycle during a grant.
- Channel switch overhead: one exit cycle in GRANT plus one IDLE cycle. Two dead read cycles per switch.
- Back-pressure: with out_ready low, reads stop once occ + inflight reaches OUT_DEPTH. At most OUT_DEPTH words are held.
- Mask cleared mid-grant: reads stop in the same cycle. The in-flight word is still delivered and counted.
- Simultaneous push and pop on the output buffer in one cycle: occ is unchanged.

## Test plan
- Single word: channel 3 holds 1 word 0xA5_1234_5678, out_ready=1 → one read pulse on bit 3 at N0+1, out_valid for one cycle at N0+3 with that word, word_count[3]=1.
- Round-robin: channels 0, 1 and 5 each hold 4 words, max_burst=2, mode 0 → grant order 0,1,5,0,1,5, two words each; 12 words out; per-channel order preserved.
- Fixed priority: channels 2 and 7 full, mode 1, max_burst=0 → channel 2 drains completely before channel 7 is granted.
- Back-pressure: out_ready=0 with channel 0 holding 10 words → exactly 4 reads, then tdc_fifo_read stays low. Releasing out_ready delivers all 10 words in order with no loss or duplication.
- Mask and saturation: clear tdc_enable_mask[4] mid-burst → reads stop the same cycle and the in-flight word is delivered. With CNT_W=4, 20 reads → word_count=15. clear_counters together with a read → count 0.
- Asynchronous reset mid-grant → all outputs 0 immediately; after release, channel 0 is granted first.

Source files
------------

// File: rtl/tdc_readout_arbiter_if.sv
// rtl/tdc_readout_arbiter_if.sv - TDC FIFO drain, merged output stream, control and counter bundle
interface tdc_readout_arbiter_if #(
    parameter int NUM_TDC = 18,
    parameter int DATA_W  = 40,
    parameter int CNT_W   = 32
);
    logic [NUM_TDC-1:0]        tdc_fifo_empty;
    logic [NUM_TDC-1:0]        tdc_fifo_read;
    logic [NUM_TDC*DATA_W-1:0] tdc_fifo_data;
    logic [NUM_TDC-1:0]        tdc_enable_mask;
    logic                      priority_mode;
    logic [7:0]                max_burst;
    logic                      clear_counters;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [4:0]                active_channel;
    logic                      arbiter_busy;
    logic [NUM_TDC*CNT_W-1:0]  word_count;

    // slave: the arbiter itself; master: the surrounding FIFOs, consumer and control
    modport slave (
        input  tdc_fifo_empty, tdc_fifo_data, tdc_enable_mask, priority_mode,
        input  max_burst, clear_counters, out_ready,
        output tdc_fifo_read, out_data, out_valid, active_channel, arbiter_busy, word_count
    );

    modport master (
        output tdc_fifo_empty, tdc_fifo_data, tdc_enable_mask, priority_mode,
        output max_burst, clear_counters, out_ready,
        input  tdc_fifo_read, out_data, out_valid, active_channel, arbiter_busy, word_count
    );
endinterface

// File: rtl/tdc_readout_arbiter.sv
// rtl/tdc_readout_arbiter.sv - N-channel TDC FIFO readout arbiter with credit-checked output buffer
module tdc_readout_arbiter #(
    parameter int NUM_TDC   = 18,
    parameter int DATA_W    = 40,
    parameter int CNT_W     = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 sys_clk_160,
    input  logic                 rst_160_n,
    tdc_readout_arbiter_if.slave bus
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(NUM_TDC);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_active;
    logic [CW-1:0]       r_rr_ptr;
    logic [7:0]          r_burst_cnt;
    logic [7:0]          r_max_burst;
    logic                r_inflight;
    logic [CW-1:0]       r_rd_ch;
    logic [DATA_W-1:0]   r_mem [OUT_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_occ;
    logic [CNT_W-1:0]    r_count [NUM_TDC];

    logic [NUM_TDC-1:0]  w_cand;
    logic                w_found;
    logic [CW-1:0]       w_sel;
    int                  w_idx;
    logic                w_exit;
    logic                w_credit;
    logic                w_rd;
    logic                w_push;
    logic                w_pop;

    // Fixed priority scans from 0; round-robin scans from r_rr_ptr with wrap.
    always_comb begin
        w_cand  = ~bus.tdc_fifo_empty & bus.tdc_enable_mask;
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_TDC; i++) begin
            w_idx = bus.priority_mode ? i : (int'(r_rr_ptr) + i) % NUM_TDC;
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_sel   = CW'(w_idx);
            end
        end
    end

    assign w_exit = bus.tdc_fifo_empty[r_active] || !bus.tdc_enable_mask[r_active] ||
                    ((r_max_burst != 8'd0) && (r_burst_cnt == r_max_burst));
    // A read is only issued when the buffer can absorb it even if nothing drains.
    assign w_credit = ({1'b0, r_occ} + {{(AW + 1){1'b0}}, r_inflight}) < (AW + 2)'(OUT_DEPTH);
    assign w_rd     = (r_state == S_GRANT) && !w_exit && w_credit;
    assign w_push   = r_inflight;
    assign w_pop    = (r_occ != '0) && bus.out_ready;

    assign bus.tdc_fifo_read  = w_rd ? (NUM_TDC'(1) << r_active) : '0;
    assign bus.out_valid      = (r_occ != '0);
    assign bus.out_data       = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;
    assign bus.active_channel = 5'(r_active);
    assign bus.arbiter_busy   = (r_state == S_GRANT) || r_inflight || (r_occ != '0);

    always_ff @(posedge sys_clk_160 or negedge rst_160_n) begin
        if (!rst_160_n) begin
            r_state     <= S_IDLE;
            r_active    <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_max_burst <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_active    <= w_sel;
                        r_burst_cnt <= '0;
                        r_max_burst <= bus.max_burst;
                        r_rr_ptr    <= (int'(w_sel) == NUM_TDC - 1) ? '0 : w_sel + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_rd) r_burst_cnt <= r_burst_cnt + 8'd1;
                    if (w_exit) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The channel travels with the read so data is taken from the FIFO actually read.
    always_ff @(posedge sys_clk_160 or negedge rst_160_n) begin
        if (!rst_160_n) begin
            r_inflight <= 1'b0;
            r_rd_ch    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            r_inflight <= w_rd;
            r_rd_ch    <= r_active;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge sys_clk_160) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.tdc_fifo_data[r_rd_ch*DATA_W +: DATA_W];
    end

    always_ff @(posedge sys_clk_160 or negedge rst_160_n) begin
        if (!rst_160_n) begin
            for (int c = 0; c < NUM_TDC; c++) r_count[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_TDC; c++) begin
                if (bus.clear_counters)
                    r_count[c] <= '0;
                else if (w_rd && (r_active == CW'(c)) && (r_count[c] != {CNT_W{1'b1}}))
                    r_count[c] <= r_count[c] + 1'b1;
            end
        end
    end

    always_comb begin
        bus.word_count = '0;
        for (int c = 0; c < NUM_TDC; c++) bus.word_count[c*CNT_W +: CNT_W] = r_count[c];
    end
endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// tb/tb_tdc_readout_arbiter.sv - self-checking bench for tdc_readout_arbiter
module tb_tdc_readout_arbiter;
    localparam int NUM_TDC   = 8;
    localparam int DATA_W    = 40;
    localparam int CNT_W     = 4;
    localparam int OUT_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdc_readout_arbiter_if #(.NUM_TDC(NUM_TDC), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    tdc_readout_arbiter #(
        .NUM_TDC(NUM_TDC), .DATA_W(DATA_W), .CNT_W(CNT_W), .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .sys_clk_160(clk),
        .rst_160_n  (rst_n),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0]         fq [NUM_TDC][$];
    logic [DATA_W-1:0]         out_exp [$];
    int                        rd_log [$];
    int                        pushed [NUM_TDC];
    logic [NUM_TDC-1:0]        empt = '1;
    logic [NUM_TDC*DATA_W-1:0] fdata = '0;
    logic [NUM_TDC-1:0]        rd_s = '0;
    int n_rd = 0, n_acc = 0, max_out = 0;
    int first_rd_cyc = -1, first_val_cyc = -1, val_cycles = 0;

    assign bus.tdc_fifo_empty = empt;
    assign bus.tdc_fifo_data  = fdata;

    typedef struct packed {
        logic [31:0] fill;
        logic        mode;
        logic [7:0]  burst;
        logic [7:0]  n;
        logic [63:0] order;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic upd_empty();
        for (int c = 0; c < NUM_TDC; c++) empt[c] = (fq[c].size() == 0);
    endtask

    task automatic load(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            fq[c].push_back({8'(c), 32'($urandom)});
            pushed[c]++;
        end
        upd_empty();
    endtask

    function automatic logic [CNT_W-1:0] wc(input int c);
        return bus.word_count[c*CNT_W +: CNT_W];
    endfunction

    function automatic bit all_empty();
        for (int c = 0; c < NUM_TDC; c++) if (fq[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_log();
        out_exp.delete();
        rd_log.delete();
        n_rd = 0; n_acc = 0;
        first_rd_cyc = -1; first_val_cyc = -1; val_cycles = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        for (int c = 0; c < NUM_TDC; c++) begin
            fq[c].delete();
            pushed[c] = 0;
        end
        clear_log();
        fdata = '0;
        upd_empty();
        bus.clear_counters  = 1'b0;
        bus.tdc_enable_mask = '1;
        bus.out_ready       = 1'b1;
        bus.priority_mode   = 1'b0;
        bus.max_burst       = 8'd0;
        step(1);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (!(all_empty() && out_exp.size() == 0 && !bus.arbiter_busy) && k < budget) begin
            step(1);
            k++;
        end
        check(name, 64'(k < budget), 64'd1);
    endtask

    task automatic check_rst_outputs(input string tag);
        check({tag, "_read"},   64'(bus.tdc_fifo_read),  64'd0);
        check({tag, "_valid"},  64'(bus.out_valid),      64'd0);
        check({tag, "_data"},   64'(bus.out_data),       64'd0);
        check({tag, "_active"}, 64'(bus.active_channel), 64'd0);
        check({tag, "_busy"},   64'(bus.arbiter_busy),   64'd0);
        check({tag, "_counts"}, 64'(bus.word_count),     64'd0);
    endtask

    // Mid-cycle sampling of the read strobes and the output handshake.
    always @(negedge clk) begin
        rd_s = bus.tdc_fifo_read;
        if (rst_n) begin
            if (rd_s != '0) begin
                if (!$onehot(rd_s)) fail_now("read_not_onehot");
                n_rd++;
                rd_log.push_back($clog2(rd_s));
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
            end
            if (bus.out_valid) begin
                val_cycles++;
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (bus.out_ready) begin
                    n_acc++;
                    if (out_exp.size() == 0) fail_now("unexpected_output");
                    else check("out_data", 64'(bus.out_data), 64'(out_exp.pop_front()));
                end
            end
        end
    end

    // Standard (non-FWFT) FIFO model: a read in cycle N presents its word in N+1.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rst_n) begin
            for (int c = 0; c < NUM_TDC; c++) begin
                if (rd_s[c]) begin
                    if (fq[c].size() == 0) fail_now("read_on_empty_fifo");
                    else begin
                        fdata[c*DATA_W +: DATA_W] = fq[c].pop_front();
                        out_exp.push_back(fdata[c*DATA_W +: DATA_W]);
                    end
                end
            end
        end
        rd_s = '0;
        upd_empty();
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0, r, k, ch;
        bit found;

        vecs[0] = '{32'h0040_0044, 1'b0, 8'd2, 8'd12, 64'h5511_0055_1100};
        vecs[1] = '{32'h5000_0500, 1'b1, 8'd0, 8'd10, 64'h77_7772_2222};
        vecs[2] = '{32'h0000_2020, 1'b1, 8'd1, 8'd4,  64'h3311};
        vecs[3] = '{32'h0000_2020, 1'b0, 8'd1, 8'd4,  64'h3131};
        vecs[4] = '{32'h0300_0100, 1'b0, 8'd0, 8'd4,  64'h6662};
        vecs[5] = '{32'h2000_0002, 1'b0, 8'd1, 8'd4,  64'h7070};

        bus.clear_counters  = 1'b0;
        bus.tdc_enable_mask = '1;
        bus.out_ready       = 1'b1;
        bus.priority_mode   = 1'b0;
        bus.max_burst       = 8'd0;
        step(1);
        check_rst_outputs("por");

        // Single word: read at N0+1, valid at N0+3
        do_reset();
        step(2);
        fq[3].push_back(40'hA5_1234_5678);
        upd_empty();
        n0 = cyc;
        wait_drain("single_drain", 100);
        check("single_rd_latency",  64'(first_rd_cyc - n0),  64'd1);
        check("single_val_latency", 64'(first_val_cyc - n0), 64'd3);
        check("single_val_cycles",  64'(val_cycles), 64'd1);
        check("single_reads",       64'(n_rd), 64'd1);
        check("single_rd_channel",  64'(rd_log.size() > 0 ? rd_log[0] : 99), 64'd3);
        check("single_count",       64'(wc(3)), 64'd1);
        check("single_active",      64'(bus.active_channel), 64'd3);

        // Table of grant-order scenarios, each from reset
        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.priority_mode = vecs[i].mode;
            bus.max_burst     = vecs[i].burst;
            step(1);
            for (int c = 0; c < NUM_TDC; c++) load(c, int'(vecs[i].fill[4*c +: 4]));
            wait_drain($sformatf("vec%0d_drain", i), 500);
            check($sformatf("vec%0d_nreads", i), 64'(rd_log.size()), 64'(vecs[i].n));
            for (int j = 0; j < int'(vecs[i].n) && j < rd_log.size(); j++)
                check($sformatf("vec%0d_read%0d", i, j), 64'(rd_log[j]), 64'(vecs[i].order[4*j +: 4]));
            for (int c = 0; c < NUM_TDC; c++)
                check($sformatf("vec%0d_count%0d", i, c), 64'(wc(c)), 64'(vecs[i].fill[4*c +: 4]));
        end

        // Back-pressure: at most OUT_DEPTH words outstanding
        do_reset();
        bus.out_ready = 1'b0;
        load(0, 10);
        step(20);
        check("bp_reads_stalled", 64'(n_rd), 64'd4);
        check("bp_valid_held",    64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        wait_drain("bp_drain", 200);
        check("bp_delivered",     64'(n_acc), 64'd10);
        check("bp_count",         64'(wc(0)), 64'd10);

        // Mask cleared mid-burst: reads stop in the same cycle
        do_reset();
        load(4, 8);
        k = 0;
        while (n_rd < 3 && k < 50) begin step(1); k++; end
        bus.tdc_enable_mask[4] = 1'b0;
        r = n_rd;
        step(10);
        check("mask_reads_before", 64'(r), 64'd3);
        check("mask_reads_stop",   64'(n_rd), 64'(r));
        check("mask_inflight_out", 64'(n_acc), 64'(r));
        check("mask_count",        64'(wc(4)), 64'(r));
        check("mask_busy_clear",   64'(bus.arbiter_busy), 64'd0);

        // Counter saturation at 15 with 20 reads
        do_reset();
        load(1, 20);
        wait_drain("sat_drain", 300);
        check("sat_delivered", 64'(n_acc), 64'd20);
        check("sat_count",     64'(wc(1)), 64'd15);

        // clear_counters coinciding with the last read wins
        do_reset();
        load(2, 6);
        found = 1'b0;
        k = 0;
        while (!found && k < 50) begin
            step(1);
            k++;
            if (bus.tdc_fifo_read[2] && fq[2].size() == 1) found = 1'b1;
        end
        check("clr_found_last_read", 64'(found), 64'd1);
        bus.clear_counters = 1'b1;
        step(1);
        bus.clear_counters = 1'b0;
        check("clr_count_now", 64'(wc(2)), 64'd0);
        step(5);
        check("clr_count_later", 64'(wc(2)), 64'd0);

        // Asynchronous reset mid-grant, then channel 0 first
        do_reset();
        load(5, 10);
        step(4);
        load(0, 2);
        load(7, 2);
        step(1);
        #1 rst_n = 1'b0;
        #1 check_rst_outputs("async");
        step(1);
        clear_log();
        step(1);
        rst_n = 1'b1;
        k = 0;
        while (rd_log.size() == 0 && k < 50) begin step(1); k++; end
        check("rst_first_grant", 64'(rd_log.size() > 0 ? rd_log[0] : 99), 64'd0);
        wait_drain("rst_drain", 500);

        // Randomised traffic against the queue scoreboard
        do_reset();
        for (int t = 0; t < 1000; t++) begin
            if (t % 50 == 0) bus.tdc_enable_mask = NUM_TDC'($urandom) | NUM_TDC'(1);
            if (t % 100 == 0) begin
                bus.priority_mode = 1'($urandom);
                bus.max_burst     = 8'($urandom_range(0, 3));
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, NUM_TDC - 1);
                if (pushed[ch] < 14) load(ch, 1);
            end
            step(1);
        end
        bus.tdc_enable_mask = '1;
        bus.out_ready       = 1'b1;
        wait_drain("rand_drain", 2000);
        r = 0;
        for (int c = 0; c < NUM_TDC; c++) begin
            r += pushed[c];
            check($sformatf("rand_count%0d", c), 64'(wc(c)), 64'(pushed[c]));
        end
        check("rand_delivered", 64'(n_acc), 64'(r));
        check("max_outstanding_within_depth", 64'(max_out <= OUT_DEPTH), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
